syscall_unit: RTL and testbench

Responder for the syscall request raised by the instruction decoder (syscall + sys_op). It services console I/O system calls for the single-cycle CPU and holds a stall to freeze PC and write-back until the service completes. For SYSCALL_INPUT_INT it supplies the register write-back value that the decoder's reg_write commits. It sits between the decoder/datapath and a byte-wide console link, with a valid/ready handshake in each direction.

---
 rtl/syscall_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_syscall_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// rtl/syscall_unit.sv - console syscall responder for the single-cycle CPU
//
// Purpose: services PRINT_INT, INPUT_INT, PRINT_CHAR and EXIT syscalls raised
// by the decoder, holding stall high until the service completes. Decimal
// output is produced by repeated subtraction of powers of ten; decimal input
// is accumulated as acc*10+digit and returned on sys_rdata for write-back.
//
// Optional feature macro: SYSCALL_ECHO_EN (echo every byte read during
// INPUT_INT back on the tx link before accepting the next one).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   syscall, sys_op, a0  request level, service code, argument register
//   stall                freeze PC/write-back while high
//   sys_rdata            read-int result, held until the next INPUT_INT
//   exit_halt            sticky halt after EXIT
//   tx_data/valid/ready  console output byte stream
//   rx_data/valid/ready  console input byte stream

`ifndef SYS_OP_LENGTH
`define SYS_OP_LENGTH 4
`endif
`ifndef SYSCALL_PRINT_INT
`define SYSCALL_PRINT_INT 1
`endif
`ifndef SYSCALL_INPUT_INT
`define SYSCALL_INPUT_INT 5
`endif
`ifndef SYSCALL_EXIT
`define SYSCALL_EXIT 10
`endif
`ifndef SYSCALL_PRINT_CHAR
`define SYSCALL_PRINT_CHAR 11
`endif

module syscall_unit #(
  parameter int MAX_DIGITS = 10,
  parameter int CHAR_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      syscall,
  input  logic [`SYS_OP_LENGTH-1:0] sys_op,
  input  logic [31:0]               a0,
  output logic                      stall,
  output logic [31:0]               sys_rdata,
  output logic                      exit_halt,
  output logic [CHAR_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [CHAR_W-1:0]         rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [`SYS_OP_LENGTH-1:0] OP_PRINT_INT  = `SYS_OP_LENGTH'(`SYSCALL_PRINT_INT);
  localparam logic [`SYS_OP_LENGTH-1:0] OP_INPUT_INT  = `SYS_OP_LENGTH'(`SYSCALL_INPUT_INT);
  localparam logic [`SYS_OP_LENGTH-1:0] OP_EXIT       = `SYS_OP_LENGTH'(`SYSCALL_EXIT);
  localparam logic [`SYS_OP_LENGTH-1:0] OP_PRINT_CHAR = `SYS_OP_LENGTH'(`SYSCALL_PRINT_CHAR);

  localparam logic [CHAR_W-1:0] CH_MINUS = CHAR_W'(8'h2D);
  localparam logic [CHAR_W-1:0] CH_ZERO  = CHAR_W'(8'h30);
  localparam logic [CHAR_W-1:0] CH_NINE  = CHAR_W'(8'h39);
  localparam logic [CHAR_W-1:0] CH_LF    = CHAR_W'(8'h0A);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_CONV,
    S_READ,
    S_DONE,
    S_HALTED
  } state_t;

  state_t             state, state_n;
  state_t             ret, ret_n;          // state to resume after an EMIT transfer
  logic [31:0]        mag, mag_n;          // CONV magnitude, reused as READ accumulator
  logic [3:0]         k, k_n;              // current decimal position in CONV
  logic [3:0]         digit, digit_n;      // subtractions done at position k
  logic               started, started_n;  // a digit has been emitted (no more zero suppression)
  logic               neg, neg_n;
  logic               seen, seen_n;        // at least one byte accepted in READ
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CHAR_W-1:0]  tx_data_n;
  logic [31:0]        rdata_n;
  logic               is_digit;
  logic [31:0]        dval;
  state_t             read_next;

  function automatic logic [31:0] pow10(input logic [3:0] e);
    case (e)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      4'd9:    pow10 = 32'd1000000000;
      default: pow10 = 32'd1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ret       <= S_DONE;
      mag       <= '0;
      k         <= '0;
      digit     <= '0;
      started   <= 1'b0;
      neg       <= 1'b0;
      seen      <= 1'b0;
      cnt       <= '0;
      tx_data   <= '0;
      sys_rdata <= '0;
    end else begin
      state     <= state_n;
      ret       <= ret_n;
      mag       <= mag_n;
      k         <= k_n;
      digit     <= digit_n;
      started   <= started_n;
      neg       <= neg_n;
      seen      <= seen_n;
      cnt       <= cnt_n;
      tx_data   <= tx_data_n;
      sys_rdata <= rdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    ret_n     = ret;
    mag_n     = mag;
    k_n       = k;
    digit_n   = digit;
    started_n = started;
    neg_n     = neg;
    seen_n    = seen;
    cnt_n     = cnt;
    tx_data_n = tx_data;
    rdata_n   = sys_rdata;

    stall     = (syscall && state == S_IDLE) || (state != S_IDLE && state != S_DONE);
    tx_valid  = (state == S_EMIT);
    rx_ready  = (state == S_READ);
    exit_halt = (state == S_HALTED);

    is_digit  = (rx_data >= CH_ZERO) && (rx_data <= CH_NINE);
    dval      = 32'(rx_data - CH_ZERO);
    read_next = (rx_data == CH_LF) ? S_DONE : S_READ;

    case (state)
      S_IDLE: begin
        if (syscall) begin
          case (sys_op)
            OP_PRINT_CHAR: begin
              tx_data_n = CHAR_W'(a0[7:0]);
              ret_n     = S_DONE;
              state_n   = S_EMIT;
            end
            OP_PRINT_INT: begin
              // Negation as unsigned makes 0x80000000 map to 2147483648.
              mag_n     = a0[31] ? -a0 : a0;
              k_n       = 4'd9;
              digit_n   = 4'd0;
              started_n = 1'b0;
              if (a0[31]) begin
                tx_data_n = CH_MINUS;
                ret_n     = S_CONV;
                state_n   = S_EMIT;
              end else begin
                state_n   = S_CONV;
              end
            end
            OP_INPUT_INT: begin
              mag_n   = '0;
              neg_n   = 1'b0;
              seen_n  = 1'b0;
              cnt_n   = '0;
              state_n = S_READ;
            end
            OP_EXIT:  state_n = S_HALTED;
            default:  state_n = S_DONE;
          endcase
        end
      end

      S_CONV: begin
        if (mag >= pow10(k)) begin
          mag_n   = mag - pow10(k);
          digit_n = digit + 4'd1;
        end else if (digit != 4'd0 || started || k == 4'd0) begin
          // Digit settled: emit it, then resume at the next lower position
          // (or finish after the units digit).
          tx_data_n = CHAR_W'(8'h30 + {4'd0, digit});
          started_n = 1'b1;
          digit_n   = 4'd0;
          ret_n     = (k == 4'd0) ? S_DONE : S_CONV;
          k_n       = (k == 4'd0) ? k : k - 4'd1;
          state_n   = S_EMIT;
        end else begin
          k_n = k - 4'd1;  // leading zero suppressed
        end
      end

      S_EMIT: begin
        if (tx_ready) state_n = ret;
      end

      S_READ: begin
        if (rx_valid) begin
          seen_n = 1'b1;
          if (rx_data == CH_LF) begin
            rdata_n = neg ? -mag : mag;
          end else if (!seen && rx_data == CH_MINUS) begin
            neg_n = 1'b1;
          end else if (is_digit && cnt < CNT_W'(MAX_DIGITS)) begin
            mag_n = (mag << 3) + (mag << 1) + dval;
            cnt_n = cnt + 1'b1;
          end
`ifdef SYSCALL_ECHO_EN
          tx_data_n = rx_data;
          ret_n     = read_next;
          state_n   = S_EMIT;
`else
          state_n   = read_next;
`endif
        end
      end

      S_DONE:   state_n = S_IDLE;
      S_HALTED: state_n = S_HALTED;
      default:  state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_unit.sv
// tb/tb_syscall_unit.sv - self-checking bench for syscall_unit
`timescale 1ns/1ps

`ifndef SYS_OP_LENGTH
`define SYS_OP_LENGTH 4
`endif
`ifndef SYSCALL_PRINT_INT
`define SYSCALL_PRINT_INT 1
`endif
`ifndef SYSCALL_INPUT_INT
`define SYSCALL_INPUT_INT 5
`endif
`ifndef SYSCALL_EXIT
`define SYSCALL_EXIT 10
`endif
`ifndef SYSCALL_PRINT_CHAR
`define SYSCALL_PRINT_CHAR 11
`endif

module tb_syscall_unit;
  localparam int MAXD = 10;
  localparam logic [`SYS_OP_LENGTH-1:0] OP_PI = `SYS_OP_LENGTH'(`SYSCALL_PRINT_INT);
  localparam logic [`SYS_OP_LENGTH-1:0] OP_II = `SYS_OP_LENGTH'(`SYSCALL_INPUT_INT);
  localparam logic [`SYS_OP_LENGTH-1:0] OP_EX = `SYS_OP_LENGTH'(`SYSCALL_EXIT);
  localparam logic [`SYS_OP_LENGTH-1:0] OP_PC = `SYS_OP_LENGTH'(`SYSCALL_PRINT_CHAR);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      syscall;
  logic [`SYS_OP_LENGTH-1:0] sys_op;
  logic [31:0]               a0;
  logic                      stall;
  logic [31:0]               sys_rdata;
  logic                      exit_halt;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] last_rdata;

  syscall_unit #(.MAX_DIGITS(MAXD), .CHAR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .sys_op(sys_op), .a0(a0),
    .stall(stall), .sys_rdata(sys_rdata), .exit_halt(exit_halt),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && tx_valid && tx_ready) tx_q.push_back(tx_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string q2s();
    string s = "";
    foreach (tx_q[i]) s = $sformatf("%s%c", s, tx_q[i]);
    return s;
  endfunction

  // Reference: decimal value of the typed line, first MAXD digits, sign only if first byte.
  function automatic logic [31:0] model_read(input string s);
    longint unsigned acc = 0;
    bit neg = 0;
    bit first = 1;
    int cnt = 0;
    logic [31:0] a32;
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0A) break;
      if (first && c == 8'h2D) neg = 1;
      else if (c >= 8'h30 && c <= 8'h39 && cnt < MAXD) begin
        acc = (acc * 10 + longint'(c - 8'h30)) % 64'h1_0000_0000;
        cnt++;
      end
      first = 0;
    end
    a32 = acc[31:0];
    return neg ? -a32 : a32;
  endfunction

  task automatic run_sys(input logic [`SYS_OP_LENGTH-1:0] op, input logic [31:0] arg,
                         input string rx_s, input bit rand_tx,
                         output bit ok, output logic [31:0] rd, output int cyc);
    int idx = 0;
    bit hs;
    tx_q.delete();
    ok = 0; rd = '0; cyc = 0;
    sys_op = op; a0 = arg; syscall = 1;
    tx_ready = rand_tx ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (idx < rx_s.len()) begin
        rx_valid = ($urandom_range(0, 3) != 0);
        rx_data  = rx_s[idx];
      end else begin
        rx_valid = 0;
      end
      hs = rx_valid && rx_ready;
      tick();
      cyc++;
      if (hs) idx++;
      if (!stall) begin
        ok = 1;
        rd = sys_rdata;
      end
      tx_ready = rand_tx ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    rx_valid = 0; syscall = 0; tx_ready = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0; syscall = 0; sys_op = '0; a0 = '0; tx_ready = 0; rx_valid = 0; rx_data = '0;
    repeat (3) tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", stall); end
    checks++; if (sys_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %0h want 0", sys_rdata); end
    checks++; if (exit_halt !== 1'b0) begin errors++; $display("FAIL reset_exit got %0h want 0", exit_halt); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txv got %0h want 0", tx_valid); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_txd got %0h want 0", tx_data); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rxr got %0h want 0", rx_ready); end
    rst_n = 1;
    tick();
    last_rdata = 32'h0;
  endtask

  task automatic test_print_zero();
    bit ok; logic [31:0] rd; int cyc;
    run_sys(OP_PI, 32'h0, "", 0, ok, rd, cyc);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pz_done got %0d want 1", ok); end
    checks++; if (q2s() != "0") begin errors++; $display("FAIL pz_tx got \"%s\" want \"0\"", q2s()); end
    checks++; if (stall !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL pz_idle got stall=%0b txv=%0b want 0 0", stall, tx_valid); end
  endtask

  task automatic test_print_min();
    bit ok; logic [31:0] rd; int cyc;
    run_sys(OP_PI, 32'h8000_0000, "", 0, ok, rd, cyc);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pmin_done got %0d want 1", ok); end
    checks++; if (q2s() != "-2147483648") begin errors++; $display("FAIL pmin_tx got \"%s\" want \"-2147483648\"", q2s()); end
    checks++; if (tx_q.size() !== 11) begin errors++; $display("FAIL pmin_len got %0d want 11", tx_q.size()); end
    else begin
      checks++; if (tx_q[0] !== 8'h2D || tx_q[10] !== 8'h38) begin errors++; $display("FAIL pmin_ends got %0h/%0h want 2d/38", tx_q[0], tx_q[10]); end
    end
  endtask

  task automatic test_backpressure();
    bit done = 0;
    tx_q.delete();
    sys_op = OP_PI; a0 = 32'd1234; syscall = 1; tx_ready = 0;
    for (int i = 0; i < 200 && !tx_valid; i++) tick();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL bp_wait got txv=%0b want 1", tx_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h31 || stall !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc %0d got txv=%0b txd=%0h stall=%0b want 1 31 1", i, tx_valid, tx_data, stall);
      end
      tick();
    end
    tx_ready = 1;
    for (int i = 0; i < 300 && !done; i++) begin tick(); if (!stall) done = 1; end
    syscall = 0; tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %0d want 1", done); end
    checks++; if (q2s() != "1234") begin errors++; $display("FAIL bp_tx got \"%s\" want \"1234\"", q2s()); end
  endtask

  task automatic test_print_char_unknown();
    bit ok; logic [31:0] rd; int cyc;
    run_sys(OP_PC, 32'hABCD_EF41, "", 1, ok, rd, cyc);
    checks++; if (q2s() != "A" || ok !== 1'b1) begin errors++; $display("FAIL pchar got \"%s\" ok=%0d want \"A\" 1", q2s(), ok); end
    run_sys(`SYS_OP_LENGTH'(0), 32'h1234, "", 0, ok, rd, cyc);
    checks++; if (ok !== 1'b1 || cyc !== 1 || tx_q.size() !== 0) begin
      errors++; $display("FAIL unknown got ok=%0d cyc=%0d tx=%0d want 1 1 0", ok, cyc, tx_q.size());
    end
    checks++; if (rd !== last_rdata) begin errors++; $display("FAIL unknown_rdata got %0h want %0h", rd, last_rdata); end
  endtask

  task automatic test_input_fixed();
    string ins[3] = '{"-42\n", "12a3\n", "\n"};
    logic [31:0] exps[3] = '{32'hFFFF_FFD6, 32'd123, 32'd0};
    bit ok; logic [31:0] rd; int cyc;
    string exp_tx;
    for (int i = 0; i < 3; i++) begin
      run_sys(OP_II, 32'h0, ins[i], 0, ok, rd, cyc);
`ifdef SYSCALL_ECHO_EN
      exp_tx = ins[i];
`else
      exp_tx = "";
`endif
      checks++; if (ok !== 1'b1 || rd !== exps[i]) begin errors++; $display("FAIL in_fixed%0d got ok=%0d rd=%0h want 1 %0h", i, ok, rd, exps[i]); end
      checks++; if (q2s() != exp_tx) begin errors++; $display("FAIL in_echo%0d got %0d bytes want %0d", i, tx_q.size(), exp_tx.len()); end
      last_rdata = exps[i];
    end
  endtask

  task automatic test_random_print();
    bit ok; logic [31:0] rd; int cyc;
    logic [31:0] v;
    string exp_s;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom_range(0, 99);
        1: v = -$urandom_range(1, 1000);
        2: v = 32'h7FFF_FFFF;
        default: v = $urandom;
      endcase
      exp_s = $sformatf("%0d", $signed(v));
      run_sys(OP_PI, v, "", 1, ok, rd, cyc);
      checks++; if (ok !== 1'b1 || q2s() != exp_s) begin errors++; $display("FAIL rprint a0=%0h got \"%s\" want \"%s\"", v, q2s(), exp_s); end
    end
    checks++; if (sys_rdata !== last_rdata) begin errors++; $display("FAIL rdata_hold got %0h want %0h", sys_rdata, last_rdata); end
  endtask

  task automatic test_random_input();
    bit ok; logic [31:0] rd; int cyc;
    string s;
    logic [31:0] exp_v;
    for (int i = 0; i < 20; i++) begin
      s = ($urandom_range(0, 2) == 0) ? "-" : "";
      for (int d = 0; d < int'($urandom_range(0, 13)); d++) begin
        if ($urandom_range(0, 9) == 0) s = {s, "x"};
        if ($urandom_range(0, 19) == 0) s = {s, "-"};
        s = $sformatf("%s%0d", s, $urandom_range(0, 9));
      end
      s = {s, "\n"};
      exp_v = model_read(s);
      run_sys(OP_II, $urandom, s, 1, ok, rd, cyc);
      checks++; if (ok !== 1'b1 || rd !== exp_v) begin errors++; $display("FAIL rinput len=%0d got ok=%0d rd=%0h want 1 %0h", s.len(), ok, rd, exp_v); end
`ifdef SYSCALL_ECHO_EN
      checks++; if (q2s() != s) begin errors++; $display("FAIL recho got %0d bytes want %0d", tx_q.size(), s.len()); end
`endif
      last_rdata = exp_v;
    end
  endtask

  task automatic test_reset_mid();
    tx_q.delete();
    sys_op = OP_PI; a0 = 32'd987654; syscall = 1; tx_ready = 1;
    for (int i = 0; i < 500 && tx_q.size() < 2; i++) tick();
    checks++; if (q2s() != "98") begin errors++; $display("FAIL rmid_pre got \"%s\" want \"98\"", q2s()); end
    rst_n = 0; syscall = 0;
    tick();
    checks++; if (stall !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h0 || rx_ready !== 1'b0 || exit_halt !== 1'b0 || sys_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_out got stall=%0b txv=%0b txd=%0h rxr=%0b halt=%0b rd=%0h want all 0",
                         stall, tx_valid, tx_data, rx_ready, exit_halt, sys_rdata);
    end
    rst_n = 1;
    repeat (20) tick();
    checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL rmid_post got %0d bytes want 2", tx_q.size()); end
    last_rdata = 32'h0;
  endtask

  task automatic test_exit();
    sys_op = OP_EX; a0 = '0; syscall = 1; tx_ready = 1;
    tick();
    for (int i = 0; i < 20; i++) begin
      syscall = $urandom_range(0, 1);
      sys_op = ($urandom_range(0, 1) != 0) ? OP_PC : OP_II;
      #1;
      checks++;
      if (exit_halt !== 1'b1 || stall !== 1'b1 || tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
        errors++; $display("FAIL exit_sticky cyc %0d got halt=%0b stall=%0b txv=%0b rxr=%0b want 1 1 0 0", i, exit_halt, stall, tx_valid, rx_ready);
      end
      tick();
    end
    rst_n = 0; syscall = 0;
    tick();
    rst_n = 1;
    tick();
    checks++; if (exit_halt !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL exit_clear got halt=%0b stall=%0b want 0 0", exit_halt, stall); end
  endtask

  initial begin
    test_reset();
    test_print_zero();
    test_print_min();
    test_backpressure();
    test_print_char_unknown();
    test_input_fixed();
    test_random_print();
    test_random_input();
    test_reset_mid();
    test_exit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
